dsi_pattern_gen: RTL and testbench



---
 rtl/dsi_pattern_gen_pkg.sv | 44 ++++
 rtl/dsi_pattern_pixel.sv | 36 +++
 rtl/dsi_pattern_gen.sv | 239 +++++++++++++++++++++++
 tb/tb_dsi_pattern_gen.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsi_pattern_gen_pkg.sv
// Shared definitions for the DSI test-pattern generator: register map, pattern modes,
// sequencer states and the colour-bar palette.
package dsi_pattern_gen_pkg;

    localparam logic [3:0] REG_PGEN_CTL   = 4'h0;
    localparam logic [3:0] REG_PGEN_XSIZE = 4'h1;
    localparam logic [3:0] REG_PGEN_YSIZE = 4'h2;
    localparam logic [3:0] REG_PGEN_VSYNC = 4'h3;
    localparam logic [3:0] REG_PGEN_COLOR = 4'h4;
    localparam logic [3:0] REG_PGEN_FCNT  = 4'h5;

    localparam logic [15:0] VSYNC_RESET = 16'd1000;
    localparam logic [23:0] PIX_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] PIX_BLACK   = 24'h000000;

    typedef enum logic [1:0] {
        MODE_BARS    = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_RAMP    = 2'd2,
        MODE_SOLID   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VSYNC = 2'd1,
        ST_IMAGE = 2'd2
    } state_e;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFF0000;
            3'd1:    c = 24'h00FF00;
            3'd2:    c = 24'h0000FF;
            3'd3:    c = 24'hFFFF00;
            3'd4:    c = 24'h00FFFF;
            3'd5:    c = 24'hFF00FF;
            3'd6:    c = 24'h808080;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dsi_pattern_pixel.sv
// Combinational pixel source: maps one coordinate plus the frame's shadowed settings
// to an RGB888 value.
module dsi_pattern_pixel
    import dsi_pattern_gen_pkg::*;
#(
    parameter int g_coord_width = 12,
    parameter int g_bar_shift   = 6
) (
    input  logic [g_coord_width-1:0] x_i,
    input  logic [g_coord_width-1:0] y_i,
    input  mode_e                    mode_i,
    input  logic                     border_i,
    input  logic [g_coord_width-1:0] xsize_i,
    input  logic [g_coord_width-1:0] ysize_i,
    input  logic [23:0]              color_i,
    output logic [23:0]              pixel_o
);

    logic on_edge;

    always_comb begin
        on_edge = (x_i == '0) || (y_i == '0) || (x_i == xsize_i) || (y_i == ysize_i);
        pixel_o = PIX_BLACK;
        if (border_i && on_edge) begin
            pixel_o = PIX_WHITE;
        end else begin
            case (mode_i)
                MODE_BARS:    pixel_o = bar_color(x_i[g_bar_shift+2:g_bar_shift]);
                MODE_CHECKER: pixel_o = (x_i[g_bar_shift] ^ y_i[g_bar_shift]) ? PIX_WHITE : PIX_BLACK;
                MODE_RAMP:    pixel_o = {x_i[7:0], x_i[7:0], x_i[7:0]};
                default:      pixel_o = color_i;
            endcase
        end
    end

endmodule

// File: rtl/dsi_pattern_gen.sv
// Parametrised test-image generator with a FIFO-style read port, host register bank,
// per-frame shadowed settings and a completed-frame counter.
module dsi_pattern_gen
    import dsi_pattern_gen_pkg::*;
#(
    parameter int g_pixels_per_clock = 1,
    parameter int g_coord_width      = 12,
    parameter int g_bar_shift        = 6
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic [3:0]                      host_a_i,
    input  logic [31:0]                     host_d_i,
    input  logic                            host_wr_i,
    output logic [31:0]                     host_d_o,
    output logic                            fifo_empty_o,
    input  logic                            fifo_rd_i,
    output logic [24*g_pixels_per_clock-1:0] fifo_pixels_o,
    output logic                            pix_vsync_o,
    output logic                            test_en_o
);

    localparam int N  = g_pixels_per_clock;
    localparam int CW = g_coord_width;
    localparam int PW = 24 * N;

    state_e          state_q, state_d;
    logic            ctl_en_q, ctl_en_d;
    mode_e           ctl_mode_q, ctl_mode_d;
    logic            ctl_border_q, ctl_border_d;
    logic [CW-1:0]   xsize_q, xsize_d;
    logic [CW-1:0]   ysize_q, ysize_d;
    logic [15:0]     vsync_len_q, vsync_len_d;
    logic [23:0]     color_q, color_d;
    logic [15:0]     fcnt_q, fcnt_d;

    logic [CW-1:0]   sh_xsize_q, sh_xsize_d;
    logic [CW-1:0]   sh_ysize_q, sh_ysize_d;
    logic [15:0]     sh_vsync_q, sh_vsync_d;
    mode_e           sh_mode_q, sh_mode_d;
    logic            sh_border_q, sh_border_d;
    logic [23:0]     sh_color_q, sh_color_d;

    logic [CW-1:0]   x_q, x_d;
    logic [CW-1:0]   y_q, y_d;
    logic [15:0]     vcnt_q, vcnt_d;
    logic            pix_vsync_q, pix_vsync_d;
    logic [PW-1:0]   pixels_q, pixels_d;
    logic [31:0]     host_d_q, host_d_d;

    logic [PW-1:0]   lane_pix;
    logic            disable_now;
    logic            shadow_load;
    logic            x_last;
    logic            y_last;
    logic            vsync_done;
    logic [15:0]     vsync_eff;
    logic            unused_host_bits;

    assign unused_host_bits = ^host_d_i[31:24];

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [CW-1:0] lane_x;
        assign lane_x = x_q + CW'(gi);
        dsi_pattern_pixel #(
            .g_coord_width (CW),
            .g_bar_shift   (g_bar_shift)
        ) u_pixel (
            .x_i      (lane_x),
            .y_i      (y_q),
            .mode_i   (sh_mode_q),
            .border_i (sh_border_q),
            .xsize_i  (sh_xsize_q),
            .ysize_i  (sh_ysize_q),
            .color_i  (sh_color_q),
            .pixel_o  (lane_pix[gi*24 +: 24])
        );
    end

    // A CTL write clearing enable acts in the same cycle so it beats a coincident read.
    assign disable_now = !ctl_en_q || (host_wr_i && (host_a_i == REG_PGEN_CTL) && !host_d_i[0]);
    assign x_last      = (x_q + CW'(N - 1)) == sh_xsize_q;
    assign y_last      = (y_q == sh_ysize_q);
    assign vsync_eff   = (sh_vsync_q == 16'd0) ? 16'd1 : sh_vsync_q;
    assign vsync_done  = ({1'b0, vcnt_q} + 17'd1) >= {1'b0, vsync_eff};

    always_comb begin
        state_d      = state_q;
        ctl_en_d     = ctl_en_q;
        ctl_mode_d   = ctl_mode_q;
        ctl_border_d = ctl_border_q;
        xsize_d      = xsize_q;
        ysize_d      = ysize_q;
        vsync_len_d  = vsync_len_q;
        color_d      = color_q;
        fcnt_d       = fcnt_q;
        sh_xsize_d   = sh_xsize_q;
        sh_ysize_d   = sh_ysize_q;
        sh_vsync_d   = sh_vsync_q;
        sh_mode_d    = sh_mode_q;
        sh_border_d  = sh_border_q;
        sh_color_d   = sh_color_q;
        x_d          = x_q;
        y_d          = y_q;
        vcnt_d       = vcnt_q;
        pixels_d     = pixels_q;
        host_d_d     = 32'd0;
        shadow_load  = 1'b0;

        if (host_wr_i) begin
            case (host_a_i)
                REG_PGEN_CTL: begin
                    ctl_en_d     = host_d_i[0];
                    ctl_mode_d   = mode_e'(host_d_i[2:1]);
                    ctl_border_d = host_d_i[3];
                end
                REG_PGEN_XSIZE: xsize_d     = host_d_i[CW-1:0];
                REG_PGEN_YSIZE: ysize_d     = host_d_i[CW-1:0];
                REG_PGEN_VSYNC: vsync_len_d = host_d_i[15:0];
                REG_PGEN_COLOR: color_d     = host_d_i[23:0];
                default: ;
            endcase
        end

        case (host_a_i)
            REG_PGEN_CTL:   host_d_d = {28'd0, ctl_border_q, ctl_mode_q, ctl_en_q};
            REG_PGEN_XSIZE: host_d_d = 32'(xsize_q);
            REG_PGEN_YSIZE: host_d_d = 32'(ysize_q);
            REG_PGEN_VSYNC: host_d_d = {16'd0, vsync_len_q};
            REG_PGEN_COLOR: host_d_d = {8'd0, color_q};
            REG_PGEN_FCNT:  host_d_d = {16'd0, fcnt_q};
            default:        host_d_d = 32'd0;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (!disable_now) begin
                    state_d     = ST_VSYNC;
                    shadow_load = 1'b1;
                end
            end
            ST_VSYNC: begin
                if (disable_now)     state_d = ST_IDLE;
                else if (vsync_done) state_d = ST_IMAGE;
                else                 vcnt_d  = vcnt_q + 16'd1;
            end
            ST_IMAGE: begin
                if (disable_now) begin
                    state_d = ST_IDLE;
                end else if (fifo_rd_i) begin
                    pixels_d = lane_pix;
                    if (x_last) begin
                        x_d = '0;
                        if (y_last) begin
                            fcnt_d      = fcnt_q + 16'd1;
                            state_d     = ST_VSYNC;
                            shadow_load = 1'b1;
                        end else begin
                            y_d = y_q + CW'(1);
                        end
                    end else begin
                        x_d = x_q + CW'(N);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Shadows take the registers as they stood before this cycle's host write.
        if (shadow_load) begin
            x_d         = '0;
            y_d         = '0;
            vcnt_d      = 16'd0;
            sh_xsize_d  = xsize_q;
            sh_ysize_d  = ysize_q;
            sh_vsync_d  = vsync_len_q;
            sh_mode_d   = ctl_mode_q;
            sh_border_d = ctl_border_q;
            sh_color_d  = color_q;
        end

        pix_vsync_d = (state_d == ST_VSYNC);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            ctl_en_q     <= 1'b0;
            ctl_mode_q   <= MODE_BARS;
            ctl_border_q <= 1'b0;
            xsize_q      <= '0;
            ysize_q      <= '0;
            vsync_len_q  <= VSYNC_RESET;
            color_q      <= 24'd0;
            fcnt_q       <= 16'd0;
            sh_xsize_q   <= '0;
            sh_ysize_q   <= '0;
            sh_vsync_q   <= 16'd0;
            sh_mode_q    <= MODE_BARS;
            sh_border_q  <= 1'b0;
            sh_color_q   <= 24'd0;
            x_q          <= '0;
            y_q          <= '0;
            vcnt_q       <= 16'd0;
            pix_vsync_q  <= 1'b0;
            pixels_q     <= '0;
            host_d_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            ctl_en_q     <= ctl_en_d;
            ctl_mode_q   <= ctl_mode_d;
            ctl_border_q <= ctl_border_d;
            xsize_q      <= xsize_d;
            ysize_q      <= ysize_d;
            vsync_len_q  <= vsync_len_d;
            color_q      <= color_d;
            fcnt_q       <= fcnt_d;
            sh_xsize_q   <= sh_xsize_d;
            sh_ysize_q   <= sh_ysize_d;
            sh_vsync_q   <= sh_vsync_d;
            sh_mode_q    <= sh_mode_d;
            sh_border_q  <= sh_border_d;
            sh_color_q   <= sh_color_d;
            x_q          <= x_d;
            y_q          <= y_d;
            vcnt_q       <= vcnt_d;
            pix_vsync_q  <= pix_vsync_d;
            pixels_q     <= pixels_d;
            host_d_q     <= host_d_d;
        end
    end

    assign fifo_empty_o  = (state_q != ST_IMAGE);
    assign fifo_pixels_o = pixels_q;
    assign pix_vsync_o   = pix_vsync_q;
    assign test_en_o     = ctl_en_q;
    assign host_d_o      = host_d_q;

endmodule

// File: tb/tb_dsi_pattern_gen.sv
// Bench for dsi_pattern_gen: two instances (1 and 2 pixels per beat) share one stimulus
// stream and are checked every cycle against a frame/beat-level reference model.
module tb_dsi_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  host_a = 4'd0;
    logic [31:0] host_d = 32'd0;
    logic        host_wr = 1'b0;
    logic        rd = 1'b0;

    logic [31:0] hd0, hd1;
    logic        empty0, empty1, vs0, vs1, en0, en1;
    logic [23:0] pix0;
    logic [47:0] pix1;

    always #5 clk = ~clk;

    dsi_pattern_gen #(.g_pixels_per_clock(1)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .host_a_i(host_a), .host_d_i(host_d),
        .host_wr_i(host_wr), .host_d_o(hd0), .fifo_empty_o(empty0), .fifo_rd_i(rd),
        .fifo_pixels_o(pix0), .pix_vsync_o(vs0), .test_en_o(en0)
    );

    dsi_pattern_gen #(.g_pixels_per_clock(2)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .host_a_i(host_a), .host_d_i(host_d),
        .host_wr_i(host_wr), .host_d_o(hd1), .fifo_empty_o(empty1), .fifo_rd_i(rd),
        .fifo_pixels_o(pix1), .pix_vsync_o(vs1), .test_en_o(en1)
    );

    typedef struct {
        int xs; int ys; int vs; int mode; bit border; int color;
    } cfg_t;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: host registers plus per-instance frame progress
    cfg_t        r;
    bit          r_en;
    int          phase   [2];   // 0 idle, 1 vsync, 2 image
    int          vs_left [2];
    int          beat    [2];
    cfg_t        f       [2];
    int          fcnt    [2];
    logic [47:0] exp_pix [2];
    logic [31:0] exp_hd  [2];
    bit          took    [2];

    logic [23:0] cap0[$];
    logic [47:0] cap1[$];
    logic [23:0] ref_seq[$];

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] ref_pixel(input cfg_t c, input int x, input int y);
        logic [7:0] g;
        if (c.border && (x == 0 || y == 0 || x == c.xs || y == c.ys)) return 24'hFFFFFF;
        case (c.mode)
            0: case ((x / 64) % 8)
                   0: return 24'hFF0000;
                   1: return 24'h00FF00;
                   2: return 24'h0000FF;
                   3: return 24'hFFFF00;
                   4: return 24'h00FFFF;
                   5: return 24'hFF00FF;
                   6: return 24'h808080;
                   default: return 24'h000000;
               endcase
            1: return ((((x / 64) + (y / 64)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
            2: begin g = 8'(x % 256); return {g, g, g}; end
            default: return 24'(c.color);
        endcase
    endfunction

    function automatic logic [47:0] ref_beat(input cfg_t c, input int n, input int b);
        int w = c.xs + 1;
        int x = (b * n) % w;
        int y = (b * n) / w;
        logic [47:0] v = '0;
        for (int k = 0; k < n; k++) v[k*24 +: 24] = ref_pixel(c, x + k, y);
        return v;
    endfunction

    function automatic logic [31:0] reg_read(input int i);
        case (host_a)
            4'd0: return {28'd0, r.border, 2'(r.mode), r_en};
            4'd1: return 32'(r.xs);
            4'd2: return 32'(r.ys);
            4'd3: return 32'(r.vs);
            4'd4: return 32'(r.color);
            4'd5: return 32'(fcnt[i]);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        r = '{xs: 0, ys: 0, vs: 1000, mode: 0, border: 1'b0, color: 0};
        r_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            phase[i] = 0; vs_left[i] = 0; beat[i] = 0; f[i] = r; fcnt[i] = 0;
            exp_pix[i] = '0; exp_hd[i] = '0; took[i] = 1'b0;
        end
    endtask

    task automatic start_frame(input int i);
        f[i] = r;
        vs_left[i] = (r.vs == 0) ? 1 : r.vs;
        beat[i] = 0;
        phase[i] = 1;
    endtask

    task automatic model_step();
        bit dis = !r_en || (host_wr && host_a == 4'd0 && !host_d[0]);
        for (int i = 0; i < 2; i++) begin
            int n = i + 1;
            exp_hd[i] = reg_read(i);
            took[i] = 1'b0;
            case (phase[i])
                0: if (!dis) start_frame(i);
                1: if (dis) phase[i] = 0;
                   else begin
                       vs_left[i]--;
                       if (vs_left[i] == 0) phase[i] = 2;
                   end
                default: if (dis) phase[i] = 0;
                   else if (rd) begin
                       exp_pix[i] = ref_beat(f[i], n, beat[i]);
                       took[i] = 1'b1;
                       beat[i]++;
                       if (beat[i] == (f[i].xs + 1) * (f[i].ys + 1) / n) begin
                           fcnt[i] = (fcnt[i] + 1) % 65536;
                           start_frame(i);
                       end
                   end
            endcase
        end
        if (host_wr) begin
            case (host_a)
                4'd0: begin r_en = host_d[0]; r.mode = int'(host_d[2:1]); r.border = host_d[3]; end
                4'd1: r.xs = int'(host_d[11:0]);
                4'd2: r.ys = int'(host_d[11:0]);
                4'd3: r.vs = int'(host_d[15:0]);
                4'd4: r.color = int'(host_d[23:0]);
                default: ;
            endcase
        end
    endtask

    initial begin : compare
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
            #1;
            if (rst_n) begin
                check("empty0", empty0, phase[0] != 2);
                check("vsync0", vs0, phase[0] == 1);
                check("pix0", pix0, exp_pix[0][23:0]);
                check("hostd0", hd0, exp_hd[0]);
                check("en0", en0, r_en);
                check("empty1", empty1, phase[1] != 2);
                check("vsync1", vs1, phase[1] == 1);
                check("pix1", pix1, exp_pix[1]);
                check("hostd1", hd1, exp_hd[1]);
                check("en1", en1, r_en);
                if (took[0]) cap0.push_back(pix0);
                if (took[1]) cap1.push_back(pix1);
            end
        end
    end

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        host_wr = 1'b1; host_a = a; host_d = d;
        $display("host write addr=%0d data=%08h", a, d);
        @(negedge clk);
        host_wr = 1'b0;
    endtask

    task automatic wait_cap(input int which, input int n, input int budget);
        int c = 0;
        while (((which == 0) ? cap0.size() : cap1.size()) < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (c >= budget) begin
            n_fail++;
            $display("FAIL beat_timeout: got %0d beats expected %0d", (which == 0) ? cap0.size() : cap1.size(), n);
        end
    endtask

    task automatic count_vsync(output int cnt);
        cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (vs0) cnt++;
            if (!empty0) break;
        end
    endtask

    initial begin : stim
        int   vcnt;
        cfg_t pc;

        repeat (3) @(negedge clk);
        check("rst_empty0", empty0, 1'b1);
        check("rst_pix1", pix1, 48'd0);
        check("rst_vsync0", vs0, 1'b0);
        check("rst_en1", en1, 1'b0);
        rst_n = 1'b1;
        @(negedge clk); host_a = 4'd3;
        @(negedge clk);
        check("rst_vsync_reg", hd0, 32'd1000);

        pc = '{xs: 127, ys: 127, vs: 1, mode: 1, border: 1'b0, color: 0};
        check("pin_checker_64_0", ref_pixel(pc, 64, 0), 24'hFFFFFF);
        check("pin_checker_64_64", ref_pixel(pc, 64, 64), 24'h000000);
        pc.mode = 0;
        check("pin_bars_x70", ref_pixel(pc, 70, 5), 24'h00FF00);

        // bars with border, 8x4, vsync 4
        rd = 1'b1;
        wr(4'd1, 32'd7); wr(4'd2, 32'd3); wr(4'd3, 32'd4);
        cap0.delete(); cap1.delete();
        wr(4'd0, 32'h9);
        count_vsync(vcnt);
        check("t1_vsync_len", 48'(vcnt), 48'd4);
        wait_cap(0, 32, 200);
        for (int b = 0; b < 9; b++) check("t1_border", cap0[b], 24'hFFFFFF);
        for (int b = 9; b < 15; b++) check("t1_row1_red", cap0[b], 24'hFF0000);
        check("t1_row1_end", cap0[15], 24'hFFFFFF);
        ref_seq.delete();
        for (int b = 0; b < 32; b++) ref_seq.push_back(cap0[b]);
        host_a = 4'd5;
        @(negedge clk);
        check("t1_fcnt", hd0, 32'd1);

        // grey ramp, 256 wide, two pixels per beat
        wr(4'd0, 32'h0); wr(4'd1, 32'd255); wr(4'd2, 32'd1); wr(4'd3, 32'd2);
        cap0.delete(); cap1.delete();
        wr(4'd0, 32'h5);
        wait_cap(1, 129, 2000);
        check("t2_beat0", cap1[0], 48'h010101_000000);
        check("t2_beat1", cap1[1], 48'h030303_020202);
        check("t2_beat127", cap1[127], 48'hFFFFFF_FEFEFE);
        check("t2_wrap", cap1[128], 48'h010101_000000);

        // checkerboard, 128 wide
        wr(4'd0, 32'h0); wr(4'd1, 32'd127); wr(4'd2, 32'd65);
        cap0.delete(); cap1.delete();
        wr(4'd0, 32'h3);
        wait_cap(0, 64 * 128 + 65, 20000);
        check("t3_x63_y0", cap0[63], 24'h000000);
        check("t3_x64_y0", cap0[64], 24'hFFFFFF);
        check("t3_x0_y64", cap0[64 * 128], 24'hFFFFFF);
        check("t3_x64_y64", cap0[64 * 128 + 64], 24'h000000);

        // solid colour, settings rewritten mid-frame
        wr(4'd0, 32'h0); wr(4'd1, 32'd7); wr(4'd2, 32'd1); wr(4'd4, 32'hABCDEF);
        cap0.delete(); cap1.delete();
        wr(4'd0, 32'h7);
        wait_cap(0, 3, 100);
        wr(4'd1, 32'd15); wr(4'd4, 32'h123456);
        wait_cap(0, 48, 400);
        for (int b = 0; b < 16; b++) check("t4_old_frame", cap0[b], 24'hABCDEF);
        for (int b = 16; b < 48; b++) check("t4_new_frame", cap0[b], 24'h123456);

        // bars again with random read gaps
        wr(4'd0, 32'h0); wr(4'd1, 32'd7); wr(4'd2, 32'd3); wr(4'd3, 32'd4);
        cap0.delete(); cap1.delete();
        wr(4'd0, 32'h9);
        for (int i = 0; i < 1000 && cap0.size() < 32; i++) begin
            @(negedge clk);
            rd = 1'($urandom_range(0, 1));
        end
        rd = 1'b1;
        wait_cap(0, 32, 10);
        for (int b = 0; b < 32; b++) check("t5_gap_seq", cap0[b], ref_seq[b]);

        // disable at y=2, then re-enable
        wr(4'd0, 32'h0);
        cap0.delete(); cap1.delete();
        wr(4'd0, 32'h9);
        wait_cap(0, 17, 200);
        wr(4'd0, 32'h0);
        check("t6_empty", empty0, 1'b1);
        check("t6_vsync", vs0, 1'b0);
        repeat (3) @(negedge clk);
        cap0.delete(); cap1.delete();
        wr(4'd0, 32'h9);
        count_vsync(vcnt);
        check("t6_vsync_len", 48'(vcnt), 48'd4);
        wait_cap(0, 10, 100);
        check("t6_first_pix", cap0[0], 24'hFFFFFF);
        check("t6_x1_y1", cap0[9], 24'hFF0000);

        // asynchronous reset mid-frame
        wait_cap(0, 20, 100);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t7_empty0", empty0, 1'b1);
        check("t7_pix0", pix0, 24'd0);
        check("t7_vsync1", vs1, 1'b0);
        check("t7_hostd0", hd0, 32'd0);
        check("t7_en0", en0, 1'b0);
        check("t7_pix1", pix1, 48'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        host_a = 4'd1;
        repeat (3) @(negedge clk);
        check("t7_xsize_cleared", hd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
